// File: rtl/deca_seq_fsm.sv
// Instruction sequencer: FETCH -> EXEC_1..EXEC_len+1 -> FETCH, with an absorbing HALT state.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   mem_ready   fetch handshake (instruction word available)
//   ext_len     execute phases minus one, sampled at the fetch handshake
//   stall       freeze the sequencer this cycle
//   halt        halt request, honoured only in FETCH
//   fetch       high while in FETCH
//   exec        one-hot execute phase (bit k-1 for EXEC_k), zero outside execute
//   halted      high while in HALT
//   instr_done  high in the cycle the final execute phase retires
//   retired     retired-instruction count, wraps silently
module deca_seq_fsm #(
    parameter int unsigned N_EXEC = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ready,
    input  logic [2:0]        ext_len,
    input  logic              stall,
    input  logic              halt,
    output logic              fetch,
    output logic [N_EXEC-1:0] exec,
    output logic              halted,
    output logic              instr_done,
    output logic [CNT_W-1:0]  retired
);

    // EXEC_k is represented as StExec together with phase_q == k-1.
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StHalt  = 2'd2
    } state_e;

    localparam logic [2:0] LenMax = 3'(N_EXEC - 1);

    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [2:0]       len_q, len_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             done;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        len_d     = len_q;
        retired_d = retired_q;
        done      = 1'b0;
        if (!stall) begin
            case (state_q)
                StFetch: begin
                    if (halt) begin
                        state_d = StHalt;
                    end else if (mem_ready) begin
                        // Saturate so the phase counter can never pass the last EXEC state.
                        len_d   = (ext_len > LenMax) ? LenMax : ext_len;
                        phase_d = 3'd0;
                        state_d = StExec;
                    end
                end
                StExec: begin
                    if (phase_q >= len_q) begin
                        state_d   = StFetch;
                        phase_d   = 3'd0;
                        retired_d = retired_q + CNT_W'(1);
                        done      = 1'b1;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StFetch;
                    phase_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            phase_q   <= 3'd0;
            len_q     <= 3'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            len_q     <= len_d;
            retired_q <= retired_d;
        end
    end

    // Outputs decode the registered state; rst overrides them so the reset cycle
    // itself already shows the post-reset values.
    always_comb begin
        fetch      = rst || (state_q == StFetch);
        halted     = !rst && (state_q == StHalt);
        instr_done = !rst && done;
        retired    = rst ? '0 : retired_q;
        for (int k = 0; k < int'(N_EXEC); k++) begin
            exec[k] = !rst && (state_q == StExec) && (phase_q == 3'(k));
        end
    end

endmodule

// File: tb/tb_deca_seq_fsm.sv
module tb_deca_seq_fsm;

    logic       clk;
    logic       rst;
    logic       mem_ready;
    logic [2:0] ext_len;
    logic       stall;
    logic       halt;

    logic       fetch_a, halted_a, done_a;
    logic [3:0] exec_a;
    logic [7:0] ret_a;
    logic       fetch_b, halted_b, done_b;
    logic [3:0] exec_b;
    logic [1:0] ret_b;
    logic       fetch_c, halted_c, done_c;
    logic [0:0] exec_c;
    logic [2:0] ret_c;

    int n_cmp = 0;
    int n_bad = 0;

    deca_seq_fsm #(.N_EXEC(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .ext_len(ext_len), .stall(stall),
        .halt(halt), .fetch(fetch_a), .exec(exec_a), .halted(halted_a),
        .instr_done(done_a), .retired(ret_a)
    );

    deca_seq_fsm #(.N_EXEC(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .ext_len(ext_len), .stall(stall),
        .halt(halt), .fetch(fetch_b), .exec(exec_b), .halted(halted_b),
        .instr_done(done_b), .retired(ret_b)
    );

    deca_seq_fsm #(.N_EXEC(1), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .ext_len(ext_len), .stall(stall),
        .halt(halt), .fetch(fetch_c), .exec(exec_c), .halted(halted_c),
        .instr_done(done_c), .retired(ret_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [2:0] el;
        logic       st;
        logic       hl;
        logic       ef;
        logic [3:0] ee;
        logic       eh;
        logic       ed;
        logic [7:0] er;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic m, input logic [2:0] l,
                                input logic s, input logic h, input logic f,
                                input logic [3:0] e, input logic hd, input logic d,
                                input logic [7:0] rt);
        vec_t v;
        v.rst = r; v.mr = m; v.el = l; v.st = s; v.hl = h;
        v.ef = f; v.ee = e; v.eh = hd; v.ed = d; v.er = rt;
        return v;
    endfunction

    // Reference model: mode 0=fetch 1=execute 2=halt; rem = execute cycles still owed.
    int m_mode[2];
    int m_phase[2];
    int m_rem[2];
    int m_cnt[2];
    int n_exec[2] = '{4, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_exec(input int i);
        if (rst || m_mode[i] != 1) return 32'd0;
        return 32'd1 << (m_phase[i] - 1);
    endfunction

    function automatic logic m_done(input int i);
        return !rst && m_mode[i] == 1 && !stall && m_rem[i] == 1;
    endfunction

    task automatic model_check();
        logic [31:0] ef0, ef1, eh0, eh1, ret;
        ef0 = {31'd0, rst || m_mode[0] == 0};
        ef1 = {31'd0, rst || m_mode[1] == 0};
        eh0 = {31'd0, !rst && m_mode[0] == 2};
        eh1 = {31'd0, !rst && m_mode[1] == 2};
        ret = rst ? 32'd0 : 32'(m_cnt[0]);
        check("a.fetch", {31'd0, fetch_a}, ef0);
        check("a.exec", {28'd0, exec_a}, m_exec(0));
        check("a.halted", {31'd0, halted_a}, eh0);
        check("a.instr_done", {31'd0, done_a}, {31'd0, m_done(0)});
        check("a.retired", {24'd0, ret_a}, ret % 256);
        check("b.fetch", {31'd0, fetch_b}, ef0);
        check("b.exec", {28'd0, exec_b}, m_exec(0));
        check("b.halted", {31'd0, halted_b}, eh0);
        check("b.instr_done", {31'd0, done_b}, {31'd0, m_done(0)});
        check("b.retired", {30'd0, ret_b}, ret % 4);
        ret = rst ? 32'd0 : 32'(m_cnt[1]);
        check("c.fetch", {31'd0, fetch_c}, ef1);
        check("c.exec", {31'd0, exec_c}, m_exec(1));
        check("c.halted", {31'd0, halted_c}, eh1);
        check("c.instr_done", {31'd0, done_c}, {31'd0, m_done(1)});
        check("c.retired", {29'd0, ret_c}, ret % 8);
    endtask

    task automatic model_step();
        int len;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = 0; m_cnt[i] = 0; m_rem[i] = 0; m_phase[i] = 0;
            end else if (!stall) begin
                if (m_mode[i] == 0) begin
                    if (halt) begin
                        m_mode[i] = 2;
                    end else if (mem_ready) begin
                        len = (int'(ext_len) < n_exec[i] - 1) ? int'(ext_len) : n_exec[i] - 1;
                        m_rem[i] = len + 1;
                        m_phase[i] = 1;
                        m_mode[i] = 1;
                    end
                end else if (m_mode[i] == 1) begin
                    if (m_rem[i] == 1) begin
                        m_mode[i] = 0;
                        m_cnt[i] = m_cnt[i] + 1;
                    end else begin
                        m_rem[i] = m_rem[i] - 1;
                        m_phase[i] = m_phase[i] + 1;
                    end
                end
            end
        end
    endtask

    // Inputs must already be applied; checks at negedge, model advances at posedge.
    task automatic tick(input bit has_vec, input vec_t v, input bit chk_b, input int exp_b);
        @(negedge clk);
        if (has_vec) begin
            check("vec.fetch", {31'd0, fetch_a}, {31'd0, v.ef});
            check("vec.exec", {28'd0, exec_a}, {28'd0, v.ee});
            check("vec.halted", {31'd0, halted_a}, {31'd0, v.eh});
            check("vec.instr_done", {31'd0, done_a}, {31'd0, v.ed});
            check("vec.retired", {24'd0, ret_a}, {24'd0, v.er});
        end
        if (chk_b) check("wrap.retired_b", {30'd0, ret_b}, 32'(exp_b));
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; mem_ready = v.mr; ext_len = v.el; stall = v.st; halt = v.hl;
        tick(1'b1, v, 1'b0, 0);
    endtask

    task automatic drive(input logic r, input logic m, input logic [2:0] l,
                         input logic s, input logic h);
        vec_t v;
        rst = r; mem_ready = m; ext_len = l; stall = s; halt = h;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1'b0, v, 1'b0, 0);
    endtask

    vec_t tbl[28];
    int   wrap_seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_phase[i] = 0; m_rem[i] = 0; m_cnt[i] = 0;
        end
        rst = 1'b1; mem_ready = 1'b0; ext_len = 3'd0; stall = 1'b0; halt = 1'b0;

        //              rst mr el st hl | fetch exec halted done retired
        tbl[0]  = mk(1, 0, 0, 0, 0,  1, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(0, 1, 2, 0, 0,  1, 4'b0000, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,  0, 4'b0001, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,  0, 4'b0010, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0,  0, 4'b0100, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,  1, 4'b0000, 0, 0, 1);
        tbl[6]  = mk(0, 1, 7, 0, 0,  1, 4'b0000, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0,  0, 4'b0001, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0,  0, 4'b0010, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0,  0, 4'b0100, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0,  0, 4'b1000, 0, 1, 1);
        tbl[11] = mk(0, 0, 0, 0, 0,  1, 4'b0000, 0, 0, 2);
        tbl[12] = mk(0, 1, 1, 0, 0,  1, 4'b0000, 0, 0, 2);
        tbl[13] = mk(0, 0, 0, 0, 0,  0, 4'b0001, 0, 0, 2);
        tbl[14] = mk(0, 1, 5, 1, 1,  0, 4'b0010, 0, 0, 2);
        tbl[15] = mk(0, 0, 0, 1, 0,  0, 4'b0010, 0, 0, 2);
        tbl[16] = mk(0, 1, 0, 1, 1,  0, 4'b0010, 0, 0, 2);
        tbl[17] = mk(0, 0, 0, 0, 0,  0, 4'b0010, 0, 1, 2);
        tbl[18] = mk(0, 0, 0, 0, 0,  1, 4'b0000, 0, 0, 3);
        tbl[19] = mk(0, 1, 1, 0, 0,  1, 4'b0000, 0, 0, 3);
        tbl[20] = mk(0, 0, 0, 0, 1,  0, 4'b0001, 0, 0, 3);
        tbl[21] = mk(0, 0, 0, 0, 1,  0, 4'b0010, 0, 1, 3);
        tbl[22] = mk(0, 1, 0, 0, 1,  1, 4'b0000, 0, 0, 4);
        tbl[23] = mk(0, 1, 0, 0, 0,  0, 4'b0000, 1, 0, 4);
        tbl[24] = mk(0, 0, 0, 1, 0,  0, 4'b0000, 1, 0, 4);
        tbl[25] = mk(0, 1, 3, 0, 1,  0, 4'b0000, 1, 0, 4);
        tbl[26] = mk(1, 1, 0, 1, 1,  1, 4'b0000, 0, 0, 0);
        tbl[27] = mk(0, 0, 0, 0, 0,  1, 4'b0000, 0, 0, 0);

        // Align to just after the first edge (reset is applied on it).
        @(posedge clk);
        model_step();
        #1;

        for (int i = 0; i < 28; i++) apply(tbl[i]);

        // Reset in EXEC_2 of a len=3 instruction abandons it.
        apply(mk(0, 1, 3, 0, 0,  1, 4'b0000, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0,  0, 4'b0001, 0, 0, 0));
        apply(mk(1, 0, 0, 0, 0,  1, 4'b0000, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0,  1, 4'b0000, 0, 0, 0));

        // Back-to-back len=0 instructions: 2-bit counter wraps 1,2,3,0,1.
        drive(1, 0, 0, 0, 0);
        rst = 1'b0; mem_ready = 1'b1; ext_len = 3'd0; stall = 1'b0; halt = 1'b0;
        for (int j = 0; j < 10; j++) begin
            vec_t v;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick(1'b0, v, (j >= 2) && (j % 2 == 0), (j >= 2) ? wrap_seq[(j / 2) - 1] : 0);
        end
        begin
            vec_t v;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick(1'b0, v, 1'b1, 1);
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 64) == 0, 1'($urandom % 2), 3'($urandom % 8),
                  ($urandom % 4) == 0, ($urandom % 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
